// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled recovery of 8-bit frames with optional
// even/odd parity and one or two stop bits, presented through a valid/ack hold register.
module uart_receiver #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_baud_rate,
    input  logic [1:0] i_parity_mode,
    input  logic       i_stop_bits,
    input  logic       i_rx,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_parity_error,
    output logic       o_framing_error,
    output logic       o_overrun,
    output logic       o_rx_busy
);

    localparam int unsigned DIV_9600   = CLK_HZ / (16 * 9600);
    localparam int unsigned DIV_19200  = CLK_HZ / (16 * 19200);
    localparam int unsigned DIV_57600  = CLK_HZ / (16 * 57600);
    localparam int unsigned DIV_115200 = CLK_HZ / (16 * 115200);
    localparam int unsigned CNT_W      = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;

    localparam logic [CNT_W-1:0] TC_9600   = CNT_W'((DIV_9600   > 0) ? DIV_9600   - 1 : 0);
    localparam logic [CNT_W-1:0] TC_19200  = CNT_W'((DIV_19200  > 0) ? DIV_19200  - 1 : 0);
    localparam logic [CNT_W-1:0] TC_57600  = CNT_W'((DIV_57600  > 0) ? DIV_57600  - 1 : 0);
    localparam logic [CNT_W-1:0] TC_115200 = CNT_W'((DIV_115200 > 0) ? DIV_115200 - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    function automatic logic [CNT_W-1:0] term_count(input logic [1:0] baud);
        logic [CNT_W-1:0] tc;
        case (baud)
            2'b00:   tc = TC_9600;
            2'b01:   tc = TC_19200;
            2'b10:   tc = TC_57600;
            default: tc = TC_115200;
        endcase
        return tc;
    endfunction

    state_t           r_state;
    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_term;
    logic [3:0]       r_phase;
    logic             r_s7;
    logic             r_s8;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_perr;
    logic             r_ferr;
    logic             r_par_en;
    logic             r_par_odd;
    logic             r_two_stop;

    logic             w_rx;
    logic             w_fall;
    logic             w_tick;
    logic [3:0]       w_phase_nxt;
    logic             w_decide;
    logic             w_wrap;
    logic             w_bit;
    logic             w_last_stop;
    logic             w_complete;
    logic             w_frame_ferr;
    logic             w_ack;

    assign w_rx         = r_sync[1];
    assign w_fall       = r_rx_prev & ~w_rx;
    assign w_tick       = (r_state != S_IDLE) && (r_cnt == r_term);
    assign w_phase_nxt  = r_phase + 4'd1;
    assign w_decide     = w_tick && (w_phase_nxt == 4'd9);
    assign w_wrap       = w_tick && (r_phase == 4'd15);
    assign w_bit        = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
    assign w_last_stop  = (r_state == S_STOP2) || ((r_state == S_STOP1) && !r_two_stop);
    assign w_complete   = w_decide && w_last_stop;
    assign w_frame_ferr = r_ferr | ~w_bit;
    assign w_ack        = i_rx_ack & o_rx_valid;

    // Two-flop synchronizer plus one more stage for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
        end
    end

    // Oversample timing and frame FSM; bit value is a 2-of-3 vote across phases 7..9.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_term     <= '0;
            r_phase    <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            o_rx_busy  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt   <= '0;
                r_phase <= '0;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
                if (w_tick) begin
                    r_phase <= w_phase_nxt;
                end
                if (w_tick && (w_phase_nxt == 4'd7)) begin
                    r_s7 <= w_rx;
                end
                if (w_tick && (w_phase_nxt == 4'd8)) begin
                    r_s8 <= w_rx;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_term     <= term_count(i_baud_rate);
                        r_par_en   <= ~i_parity_mode[1];
                        r_par_odd  <= i_parity_mode[0];
                        r_two_stop <= i_stop_bits;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        o_rx_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_decide && w_bit) begin
                        r_state   <= S_IDLE;
                        o_rx_busy <= 1'b0;
                    end else if (w_wrap) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[7:1]};
                    end
                    if (w_wrap) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                        end
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_perr <= w_bit ^ (^r_shift) ^ r_par_odd;
                    end
                    if (w_wrap) begin
                        r_state <= S_STOP1;
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (w_decide && !w_bit) begin
                        r_ferr <= 1'b1;
                    end
                    // Leave at the mid-bit decision so the next start edge is not missed.
                    if (w_complete) begin
                        r_state   <= S_IDLE;
                        o_rx_busy <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= S_STOP2;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    o_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Hold register: an ack in the completion cycle frees the slot for the new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data       <= '0;
            o_rx_valid      <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
            o_overrun       <= 1'b0;
        end else if (w_complete && (!o_rx_valid || w_ack)) begin
            o_rx_data       <= r_shift;
            o_parity_error  <= r_perr;
            o_framing_error <= w_frame_ferr;
            o_rx_valid      <= 1'b1;
            o_overrun       <= 1'b0;
        end else if (w_complete) begin
            o_overrun <= 1'b1;
        end else if (w_ack) begin
            o_rx_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frame driver, frame-level reference
// model of the hold register, and a per-cycle compare while the line is idle.
module tb_uart_receiver;

    localparam int unsigned CLK_HZ = 3_686_400;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] baud   = 2'b11;
    logic [1:0] pmode  = 2'b10;
    logic       stop2  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_baud_rate    (baud),
        .i_parity_mode  (pmode),
        .i_stop_bits    (stop2),
        .i_rx           (rx),
        .i_rx_ack       (rx_ack),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_parity_error (perr),
        .o_framing_error(ferr),
        .o_overrun      (ovr),
        .o_rx_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model: the byte the receiver should be holding, and the overrun flag.
    bit         m_held = 1'b0;
    bit         m_ovr  = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_perr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         quiet  = 1'b0;

    int busy_rise  = -1;
    int busy_fall  = -1;
    int valid_rise = -1;
    bit p_busy     = 1'b0;
    bit p_valid    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        int baud_hz;
        case (b)
            2'b00:   baud_hz = 9600;
            2'b01:   baud_hz = 19200;
            2'b10:   baud_hz = 57600;
            default: baud_hz = 115200;
        endcase
        return int'(CLK_HZ) / (16 * baud_hz);
    endfunction

    function automatic int nominal(input logic [1:0] b);
        return 16 * div_of(b);
    endfunction

    always @(negedge clk) begin
        if (busy === 1'b1 && !p_busy) busy_rise = cyc;
        if (busy === 1'b0 && p_busy) busy_fall = cyc;
        if (rx_valid === 1'b1 && !p_valid) valid_rise = cyc;
        p_busy  = (busy === 1'b1);
        p_valid = (rx_valid === 1'b1);
        if (quiet && rst_n) begin
            chk("valid", rx_valid, m_held);
            chk("overrun", ovr, m_ovr);
            chk("busy_idle", busy, 0);
            if (m_held) begin
                chk("data", rx_data, m_data);
                chk("parity_err", perr, m_perr);
                chk("framing_err", ferr, m_ferr);
            end
        end
    end

    task automatic model_complete(input logic [7:0] d, input bit pe, input bit fe);
        if (!m_held) begin
            m_held = 1'b1;
            m_data = d;
            m_perr = pe;
            m_ferr = fe;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        quiet  = 1'b0;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
        if (m_held) begin
            m_held = 1'b0;
            m_ovr  = 1'b0;
        end
        quiet = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_perr"}, perr, 0);
        chk({tag, "_ferr"}, ferr, 0);
        chk({tag, "_ovr"}, ovr, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Drives one frame; rst_bit >= 0 aborts it with a reset halfway through that bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] pm,
                              input bit two, input bit pbit, input bit s1, input bit s2,
                              input int bc, input bit scramble, input int rst_bit);
        logic [11:0] bits;
        int nbits, idx, t0, exp_fall;
        bit acc, pe, fe;
        nbits = 10 + (pm[1] ? 0 : 1) + (two ? 1 : 0);
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        idx = 9;
        if (!pm[1]) begin
            bits[idx] = pbit;
            idx++;
        end
        bits[idx] = s1;
        idx++;
        if (two) bits[idx] = s2;

        @(posedge clk); #1;
        baud = b; pmode = pm; stop2 = two;
        quiet = 1'b0;
        busy_rise = -1; busy_fall = -1; valid_rise = -1;
        t0 = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            if (i == 1 && scramble) begin
                baud  = 2'($urandom);
                pmode = 2'($urandom);
                stop2 = 1'($urandom);
            end
            if (i == rst_bit) begin
                repeat (bc / 2) @(posedge clk);
                #1;
                rx = 1'b1;
                rst_n = 1'b0;
                #1;
                check_reset_values("midframe_rst");
                m_held = 1'b0;
                m_ovr  = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                quiet = 1'b1;
                return;
            end
            repeat (bc) @(posedge clk);
            #1;
        end
        rx = 1'b1;

        pe  = pm[1] ? 1'b0 : (pbit != (^d ^ pm[0]));
        fe  = !s1 || (two && !s2);
        acc = !m_held;
        model_complete(d, pe, fe);
        if (bc == nominal(b)) begin
            exp_fall = t0 + 3 + (16 * (nbits - 1) + 9) * div_of(b);
            chk("busy_rise_time", busy_rise, t0 + 3);
            chk("busy_fall_time", busy_fall, exp_fall);
            if (acc) chk("valid_rise_time", valid_rise, exp_fall);
        end
        quiet = 1'b1;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [1:0] b, pm;
        bit two, pbit, s1, s2;
        int r, nom, m, bc, t0;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        quiet = 1'b1;

        // 0xA5, 8N1 at the fastest rate, held until acknowledged.
        send_frame(8'hA5, 2'b11, 2'b10, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        repeat (100) @(posedge clk);
        #1;
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_perr", perr, 0);
        chk("a5_ferr", ferr, 0);
        do_ack();
        chk("a5_valid_after_ack", rx_valid, 0);

        // Parity: 0x07 has odd weight, so even parity expects a 1 and odd parity a 0.
        send_frame(8'h07, 2'b11, 2'b00, 0, 1, 1, 1, nominal(2'b11), 0, -1);
        chk("even_p1_perr", perr, 0);
        do_ack();
        send_frame(8'h07, 2'b11, 2'b00, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        chk("even_p0_perr", perr, 1);
        do_ack();
        send_frame(8'h07, 2'b11, 2'b01, 0, 1, 1, 1, nominal(2'b11), 0, -1);
        chk("odd_p1_perr", perr, 1);
        do_ack();
        send_frame(8'h07, 2'b11, 2'b01, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        chk("odd_p0_perr", perr, 0);
        do_ack();

        // Two stop bits with the second one low.
        send_frame(8'h3C, 2'b11, 2'b10, 1, 0, 1, 0, nominal(2'b11), 0, -1);
        chk("stop2_ferr", ferr, 1);
        chk("stop2_data", rx_data, 8'h3C);
        do_ack();

        // Back-to-back frames without acknowledge.
        send_frame(8'h11, 2'b11, 2'b10, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        send_frame(8'h22, 2'b11, 2'b10, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_flag", ovr, 1);
        do_ack();
        chk("ovr_valid_cleared", rx_valid, 0);
        chk("ovr_flag_cleared", ovr, 0);
        do_ack();
        chk("idle_ack_ignored", rx_valid, 0);

        // Short low glitch: a false start that must not deliver anything.
        @(posedge clk); #1;
        baud = 2'b11; pmode = 2'b10; stop2 = 1'b0;
        quiet = 1'b0;
        busy_rise = -1; busy_fall = -1;
        t0 = cyc;
        rx = 1'b0;
        repeat (4 * div_of(2'b11)) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        quiet = 1'b1;
        chk("glitch_busy_rise", busy_rise, t0 + 3);
        chk("glitch_busy_fall", busy_fall, t0 + 3 + 9 * div_of(2'b11));
        chk("glitch_no_valid", rx_valid, 0);
        send_frame(8'h5A, 2'b11, 2'b10, 0, 0, 1, 1, nominal(2'b11), 0, -1);
        chk("after_glitch_data", rx_data, 8'h5A);
        do_ack();

        // Reset during data bit 3, then a full frame at 9600 with odd parity.
        send_frame(8'h96, 2'b11, 2'b10, 0, 0, 1, 1, nominal(2'b11), 0, 4);
        send_frame(8'hC3, 2'b00, 2'b01, 1, 1, 1, 1, nominal(2'b00), 0, -1);
        chk("after_rst_data", rx_data, 8'hC3);
        chk("after_rst_perr", perr, 0);
        chk("after_rst_ferr", ferr, 0);
        do_ack();

        // Break: line held low well past a frame; no second frame may start.
        @(posedge clk); #1;
        baud = 2'b11; pmode = 2'b10; stop2 = 1'b0;
        quiet = 1'b0;
        rx = 1'b0;
        repeat (14 * nominal(2'b11)) @(posedge clk);
        #1;
        model_complete(8'h00, 0, 1);
        quiet = 1'b1;
        repeat (3 * nominal(2'b11)) @(posedge clk);
        #1;
        chk("break_data", rx_data, 8'h00);
        chk("break_ferr", ferr, 1);
        rx = 1'b1;
        repeat (2 * nominal(2'b11)) @(posedge clk);
        #1;
        do_ack();

        // Randomized frames: config, errors, sender rate offset and occasional missed acks.
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            r    = int'($urandom_range(0, 9));
            b    = (r < 5) ? 2'b11 : ((r < 8) ? 2'b10 : 2'b01);
            pm   = 2'($urandom);
            two  = 1'($urandom);
            pbit = (^d ^ pm[0]) ^ (int'($urandom_range(0, 3)) == 0);
            s1   = (int'($urandom_range(0, 6)) != 0);
            s2   = (int'($urandom_range(0, 6)) != 0);
            nom  = nominal(b);
            m    = nom / 50;
            bc   = nom + int'($urandom_range(0, 2 * m)) - m;
            send_frame(d, b, pm, two, pbit, s1, s2, bc, 1, -1);
            repeat (int'($urandom_range(0, 5))) @(posedge clk);
            #1;
            if (int'($urandom_range(0, 4)) != 0) do_ack();
        end
        do_ack();
        repeat (20) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
